intr_vec_dispatch: RTL

//  Dispatcher between the interrupt encoder (vec_req/vec_num pulse interface)
//  and the CPU. Latches each vector event into a per-vector pending register,

---
 rtl/intr_vec_dispatch.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/intr_vec_dispatch.sv
// Interrupt vector dispatcher: latches encoder events into pending bits, masks them,
// offers one vector round-robin to the CPU and tracks it in service until EOI or timeout.
module intr_vec_dispatch #(
    parameter int unsigned PORTS   = 32,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned W      = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_req,
    input  logic [W-1:0]     vec_num,
    input  logic             mask_wr,
    input  logic [PORTS-1:0] mask_data,
    output logic             cpu_valid,
    output logic [W-1:0]     cpu_num,
    input  logic             cpu_ready,
    input  logic             eoi,
    input  logic [W-1:0]     eoi_num,
    output logic [PORTS-1:0] pending,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SELECT  = 2'd1;
    localparam logic [1:0] S_OFFER   = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PORTS-1:0] pending_q, pending_d;
    logic [PORTS-1:0] enable_q, enable_d;
    logic [W-1:0]     last_q, last_d;
    logic [W-1:0]     sel_q, sel_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             vec_req_q;
    logic             tmo_q, tmo_d;

    logic             rise;
    logic [PORTS-1:0] set_v, clr_v, cand;
    logic             found;
    logic [W-1:0]     nxt;
    logic [31:0]      idx;

    assign rise = vec_req & ~vec_req_q;
    assign cand = pending_q & enable_q;

    // Out-of-range vector numbers never match a bit and are dropped.
    always_comb begin
        set_v = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            set_v[i] = rise && (32'(vec_num) == i);
        end
    end

    always_comb begin
        found = 1'b0;
        nxt   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            idx = (32'(last_q) + 32'd1 + i) % PORTS;
            if (!found && cand[idx[W-1:0]]) begin
                found = 1'b1;
                nxt   = idx[W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        timer_d  = timer_q;
        tmo_d    = 1'b0;
        clr_v    = '0;
        enable_d = mask_wr ? mask_data : enable_q;
        case (state_q)
            S_IDLE: begin
                if (|cand) state_d = S_SELECT;
            end
            S_SELECT: begin
                if (found) begin
                    sel_d   = nxt;
                    state_d = S_OFFER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OFFER: begin
                if (cpu_ready) begin
                    clr_v[sel_q] = 1'b1;
                    last_d       = sel_q;
                    timer_d      = TW'(TIMEOUT);
                    state_d      = S_SERVICE;
                end
            end
            default: begin
                if (eoi && (eoi_num == sel_q)) begin
                    state_d = S_IDLE;
                end else if (TIMEOUT != 0) begin
                    timer_d = timer_q - TW'(1);
                    if (timer_q == TW'(1)) begin
                        tmo_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        // A new event on the vector being accepted keeps it pending.
        pending_d = (pending_q & ~clr_v) | set_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            enable_q  <= '1;
            last_q    <= W'(PORTS - 1);
            sel_q     <= '0;
            timer_q   <= '0;
            vec_req_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            vec_req_q <= vec_req;
            tmo_q     <= tmo_d;
        end
    end

    assign cpu_valid   = (state_q == S_OFFER);
    assign cpu_num     = sel_q;
    assign pending     = pending_q;
    assign busy        = (state_q == S_OFFER) || (state_q == S_SERVICE);
    assign timeout_err = tmo_q;

endmodule
